// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types and constants for the front end.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents:
//   DPW              datapath width (PC / address width)
//   BtbEntries       default BTB size used by fetch_stage
//   ResetVecDefault  default PC loaded on reset
//   bp_ctr_t         2-bit saturating branch counter plus named states
//   btb_entry_t      one BTB line {valid, tag, target, ctr}
package rv32i_pkg;

  localparam int DPW        = 32;
  localparam int BtbEntries = 16;

  localparam logic [DPW-1:0] ResetVecDefault = 32'h0000_0000;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t CTR_SNT = 2'b00;  // strongly not-taken
  localparam bp_ctr_t CTR_WNT = 2'b01;  // weakly not-taken (reset state)
  localparam bp_ctr_t CTR_WT  = 2'b10;  // weakly taken (fresh allocation)
  localparam bp_ctr_t CTR_ST  = 2'b11;  // strongly taken

  // The tag is kept as a full-width field holding PC >> (IW+2). The upper
  // IW+2 bits are always zero, which keeps the struct independent of the
  // BTB size chosen by the instantiating module.
  typedef struct packed {
    logic           valid;
    logic [DPW-1:0] tag;
    logic [DPW-1:0] target;
    bp_ctr_t        ctr;
  } btb_entry_t;

  function automatic logic [DPW-1:0] btb_tag(input logic [DPW-1:0] pc,
                                             input int             iw);
    return pc >> (iw + 2);
  endfunction

  function automatic bp_ctr_t ctr_inc(input bp_ctr_t c);
    return (c == CTR_ST) ? c : c + 2'd1;
  endfunction

  function automatic bp_ctr_t ctr_dec(input bp_ctr_t c);
    return (c == CTR_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Latency: lookup is combinational; an update becomes visible the cycle after.
// Backpressure: none; an update is accepted every cycle it is presented.
//
// Ports:
//   clk, arst_n                  clock, async active-low reset
//   lookup_pc                    PC being fetched
//   hit, pred_taken, pred_target lookup result; pred_target is the raw stored
//                                target (qualify with hit)
//   update, upd_pc, upd_taken, upd_target  resolved control-flow from execute
module btb
  import rv32i_pkg::*;
#(
  parameter int ENTRIES = BtbEntries
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic [DPW-1:0] lookup_pc,
  output logic           hit,
  output logic           pred_taken,
  output logic [DPW-1:0] pred_target,
  input  logic           update,
  input  logic [DPW-1:0] upd_pc,
  input  logic           upd_taken,
  input  logic [DPW-1:0] upd_target
);

  localparam int IW = $clog2(ENTRIES);

  btb_entry_t mem [ENTRIES];

  logic [IW-1:0]  lk_idx;
  logic [DPW-1:0] lk_tag;
  btb_entry_t     lk_ent;

  logic [IW-1:0]  up_idx;
  logic [DPW-1:0] up_tag;
  btb_entry_t     up_ent;
  logic           up_match;
  logic           up_wen;
  btb_entry_t     up_new;

  // Lookup. The array is only written at the clock edge, so a same-cycle
  // update to this index is naturally read-before-write.
  always_comb begin
    lk_idx      = lookup_pc[IW+1:2];
    lk_tag      = btb_tag(lookup_pc, IW);
    lk_ent      = mem[lk_idx];
    hit         = lk_ent.valid && (lk_ent.tag == lk_tag);
    pred_taken  = hit && lk_ent.ctr[1];
    pred_target = lk_ent.target;
  end

  // Update. A hit trains the counter; a taken miss evicts whatever lives at
  // the index; a not-taken miss is not worth a BTB slot and is dropped.
  always_comb begin
    up_idx   = upd_pc[IW+1:2];
    up_tag   = btb_tag(upd_pc, IW);
    up_ent   = mem[up_idx];
    up_match = up_ent.valid && (up_ent.tag == up_tag);
    up_new   = up_ent;
    up_wen   = 1'b0;
    if (update) begin
      if (up_match) begin
        up_wen = 1'b1;
        if (upd_taken) begin
          up_new.ctr    = ctr_inc(up_ent.ctr);
          up_new.target = upd_target;
        end else begin
          up_new.ctr    = ctr_dec(up_ent.ctr);
        end
      end else if (upd_taken) begin
        up_wen        = 1'b1;
        up_new.valid  = 1'b1;
        up_new.tag    = up_tag;
        up_new.target = upd_target;
        up_new.ctr    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].valid  <= 1'b0;
        mem[i].tag    <= '0;
        mem[i].target <= '0;
        mem[i].ctr    <= CTR_WNT;
      end
    end else if (up_wen) begin
      mem[up_idx] <= up_new;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PCF, predicts the next fetch address through the BTB.
// Latency: PCF updates one cycle after the controlling input is sampled.
// Backpressure: stallF holds PCF; redirectE overrides stallF; BTB updates
//               are never held off.
//
// Ports:
//   clk, arst_n                       clock, async active-low reset
//   stallF                            hold PCF
//   redirectE, PCRedirE               execute-stage correction of the PC
//   updateE, PCE, takenE, targetE     resolved control-flow for BTB training
//   PCF                               current fetch PC
//   PredTakenF, PredTargetF           prediction for PCF (target 0 on miss)
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [DPW-1:0] RESET_VEC   = ResetVecDefault,
  parameter int             BTB_ENTRIES = BtbEntries
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           stallF,
  input  logic           redirectE,
  input  logic [DPW-1:0] PCRedirE,
  input  logic           updateE,
  input  logic [DPW-1:0] PCE,
  input  logic           takenE,
  input  logic [DPW-1:0] targetE,
  output logic [DPW-1:0] PCF,
  output logic           PredTakenF,
  output logic [DPW-1:0] PredTargetF
);

  logic           btb_hit;
  logic           btb_taken;
  logic [DPW-1:0] btb_target;
  logic [DPW-1:0] pc_next;

  btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .arst_n      (arst_n),
    .lookup_pc   (PCF),
    .hit         (btb_hit),
    .pred_taken  (btb_taken),
    .pred_target (btb_target),
    .update      (updateE),
    .upd_pc      (PCE),
    .upd_taken   (takenE),
    .upd_target  (targetE)
  );

  // Decode sees the target even for a not-taken hit; a miss reports zero so
  // nothing stale from an aliased entry leaks downstream.
  assign PredTakenF  = btb_taken;
  assign PredTargetF = btb_hit ? btb_target : '0;

  // Redirect wins over stall: a mispredict must be corrected even while the
  // hazard unit is holding fetch, otherwise the wrong path would resume.
  always_comb begin
    if (redirectE) begin
      pc_next = PCRedirE;
    end else if (stallF) begin
      pc_next = PCF;
    end else if (PredTakenF) begin
      pc_next = PredTargetF;
    end else begin
      pc_next = PCF + DPW'(4);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      PCF <= RESET_VEC;
    end else begin
      PCF <= pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        stallF;
  logic        redirectE;
  logic [31:0] PCRedirE;
  logic        updateE;
  logic [31:0] PCE;
  logic        takenE;
  logic [31:0] targetE;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_VEC   (32'h0000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .stallF      (stallF),
    .redirectE   (redirectE),
    .PCRedirE    (PCRedirE),
    .updateE     (updateE),
    .PCE         (PCE),
    .takenE      (takenE),
    .targetE     (targetE),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] pc);
    redirectE = 1'b1;
    PCRedirE  = pc;
    tick();
    redirectE = 1'b0;
    PCRedirE  = 32'h0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt);
    updateE = 1'b1;
    PCE     = pc;
    takenE  = tk;
    targetE = tgt;
  endtask

  task automatic upd_off();
    updateE = 1'b0;
    PCE     = 32'h0;
    takenE  = 1'b0;
    targetE = 32'h0;
  endtask

  task automatic pred(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tgt);
    check({tag, "_pc"}, PCF, pc);
    check({tag, "_tk"}, 32'(PredTakenF), 32'(tk));
    check({tag, "_tgt"}, PredTargetF, tgt);
  endtask

  initial begin
    arst_n    = 1'b0;
    stallF    = 1'b0;
    redirectE = 1'b0;
    PCRedirE  = 32'h0;
    upd_off();

    // Power-on reset
    tick();
    pred("por", 32'h0, 1'b0, 32'h0);
    arst_n = 1'b1;

    // Mid-run asynchronous reset from PCF=0x40
    redir(32'h40);
    check("pre_rst", PCF, 32'h40);
    #2 arst_n = 1'b0;
    #1 pred("async_rst", 32'h0, 1'b0, 32'h0);
    tick();
    arst_n = 1'b1;
    pred("rel0", 32'h0, 1'b0, 32'h0);
    tick();
    pred("rel1", 32'h4, 1'b0, 32'h0);
    tick();
    pred("rel2", 32'h8, 1'b0, 32'h0);

    // Stall holds, redirect overrides stall
    redir(32'h10);
    stallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", PCF, 32'h10);
    end
    redir(32'h200);
    stallF = 1'b0;
    check("stall_redir", PCF, 32'h200);

    // Allocate 0x20 -> 0x80, then predict
    upd(32'h20, 1'b1, 32'h80);
    tick();
    upd_off();
    check("alloc_seq", PCF, 32'h204);
    redir(32'h20);
    pred("alloc_hit", 32'h20, 1'b1, 32'h80);
    tick();
    check("alloc_jump", PCF, 32'h80);

    // Hysteresis: 2 -> 1 -> 0 -> 0 (floor), then 1 (still not-taken), then 2
    upd(32'h20, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    upd_off();
    redir(32'h20);
    pred("ctr0", 32'h20, 1'b0, 32'h80);
    tick();
    check("ctr0_next", PCF, 32'h24);
    upd(32'h20, 1'b1, 32'h80);
    tick();
    upd_off();
    redir(32'h20);
    pred("ctr1", 32'h20, 1'b0, 32'h80);
    // Second taken update while PCF sits on 0x20: lookup sees old counter
    upd(32'h20, 1'b1, 32'h80);
    tick();
    upd_off();
    check("ctr1_rbw", PCF, 32'h24);
    redir(32'h20);
    pred("ctr2", 32'h20, 1'b1, 32'h80);
    tick();
    check("ctr2_jump", PCF, 32'h80);

    // Alias at 0x60 shares index with 0x20
    redir(32'h60);
    pred("alias_miss", 32'h60, 1'b0, 32'h0);
    tick();
    check("alias_seq", PCF, 32'h64);
    upd(32'h60, 1'b0, 32'h0);
    tick();
    upd_off();
    redir(32'h20);
    pred("alias_keep", 32'h20, 1'b1, 32'h80);
    upd(32'h60, 1'b1, 32'h100);
    tick();
    upd_off();
    check("alias_old_pred", PCF, 32'h80);
    redir(32'h20);
    pred("alias_evicted", 32'h20, 1'b0, 32'h0);
    redir(32'h60);
    pred("alias_new", 32'h60, 1'b1, 32'h100);

    // Same-cycle allocate and lookup of 0x20
    redir(32'h20);
    upd(32'h20, 1'b1, 32'h300);
    pred("same_cyc", 32'h20, 1'b0, 32'h0);
    tick();
    upd_off();
    check("same_cyc_next", PCF, 32'h24);
    redir(32'h20);
    pred("same_cyc_visit", 32'h20, 1'b1, 32'h300);
    tick();
    check("same_cyc_jump", PCF, 32'h300);

    // Update performed in the same cycle as a redirect
    upd(32'h44, 1'b1, 32'h500);
    redir(32'h40);
    upd_off();
    check("redir_upd_pc", PCF, 32'h40);
    tick();
    pred("redir_upd", 32'h44, 1'b1, 32'h500);

    // PC wrap at the top of the address space
    redir(32'hFFFF_FFFC);
    check("wrap_top", PCF, 32'hFFFF_FFFC);
    tick();
    pred("wrap", 32'h0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline. Owns the PC register (PCF) and generates the next fetch address.
- Contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for next-PC prediction.
- PCF feeds decode_stage, which performs the i_cache lookup. Prediction outputs travel down the pipeline with the instruction.
- Execute resolves branches and returns a redirect and a BTB update.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; rising edge.
- arst_n  input  1  reset; asynchronous, active-low.
- stallF  input  1  hold PCF (hazard unit).
- redirectE  input  1  execute-stage mispredict/jump correction.
- PCRedirE  input  DPW  correct next PC when redirectE is high.
- updateE  input  1  resolved control-flow instruction in EX; update the BTB.
- PCE  input  DPW  PC of the resolved instruction.
- takenE  input  1  resolved direction.
- targetE  input  DPW  resolved target.
- PCF  output  DPW  current fetch PC.
- PredTakenF  output  1  BTB predicts taken for PCF.
- PredTargetF  output  DPW  predicted target; 0 when there is no hit.

Behaviour:
- Reset (arst_n low, asynchronous):
  - PCF = RESET_VEC.
  - All BTB valid bits = 0, all counters = 2'b01.
  - PredTakenF = 0, PredTargetF = 0 immediately after reset.
- BTB indexing, with IW = log2(BTB_ENTRIES):
  - index = PC[IW+1:2]
  - tag = PC[DPW-1:IW+2]
  - PC[1:0] is ignored.
- Lookup (combinational on PCF):
  - hit = valid[idx] && tag[idx] == tagF.
  - PredTakenF = hit && ctr[idx][1].
  - PredTargetF = hit ? target[idx] : 0.
- Next-PC priority, applied at the clock edge:
  1. redirectE: PCF <= PCRedirE. This overrides stallF.
  2. stallF: PCF holds.
  3. PredTakenF: PCF <= PredTargetF.
  4. Otherwise: PCF <= PCF + 4, modulo 2^DPW; 32'hFFFF_FFFC wraps to 0.
- Latency: redirect is visible on PCF one cycle after redirectE is sampled. There are no bubbles inside this block; flushing decode is the hazard unit's job.
- BTB update (synchronous, on updateE, entry at PCE's index). Let "match" = valid && tag equal.
  - Match, takenE=1: ctr = min(ctr+1, 3); target <= targetE.
  - Match, takenE=0: ctr = max(ctr-1, 0); target unchanged.
  - No match, takenE=1: allocate and replace; valid=1, tag=PCE tag, target=targetE, ctr=2'b10.
  - No match, takenE=0: no change.
- Update is independent of stallF and redirectE. An update in the same cycle as a redirect is performed.
- Simultaneous lookup and update at the same index: the lookup uses the pre-update contents (read-before-write). The new contents are visible the next cycle.
- No X on outputs after reset. Counters never wrap.

Decomposition:
- rv32i_pkg (existing DPW): add the following.
  - BtbEntries default.
  - RESET_VEC constant.
  - typedef bp_ctr_t (logic [1:0]) with constants.
  - typedef btb_entry_t struct {valid, tag, target, ctr}.
- Sub-module btb:
  - Storage plus lookup/update logic.
  - Ports: clk, arst_n, lookup_pc, hit, pred_taken, pred_target, update, upd_pc, upd_taken, upd_target.
- fetch_stage instantiates btb and holds the PC register and the next-PC mux.

Test Plan:
- Reset: hold arst_n low mid-run with PCF=0x40 -> PCF=0x0 immediately (asynchronous); after release, PCF sequence is 0x0, 0x4, 0x8; PredTakenF=0 throughout.
- Stall vs redirect: PCF=0x10, stallF=1 for 3 cycles -> PCF stays 0x10; stallF=1 with redirectE=1, PCRedirE=0x200 -> PCF=0x200 next cycle.
- Allocate/predict: update PCE=0x20, takenE=1, targetE=0x80; then fetch reaches 0x20 -> PredTakenF=1, PredTargetF=0x80, next PCF=0x80.
- Counter hysteresis: after allocation (ctr=2), two not-taken updates at 0x20 -> ctr=0, predicts not-taken, next PC 0x24; one taken update -> ctr=1, still not-taken; a second taken update -> predicts taken.
- Alias: entry at 0x20 valid; lookup at 0x20 + 4*BTB_ENTRIES (0x60 for 16 entries) -> hit=0, PC+4. A not-taken update there leaves the 0x20 entry intact; a taken update replaces it.
- Same-cycle update/lookup: PCF=0x20 while updateE allocates 0x20 -> this cycle PredTakenF=0; the next visit predicts taken.
